// File: rtl/imem_port_arbiter.sv
// Two-requester (IF / LS) arbiter for a combinational-read instruction memory port.
// Optional conflict counter output o_perf_conflicts is enabled by defining IMEM_ARB_PERF_EN.
module imem_port_arbiter #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_ls_req,
  input  logic [31:0] i_ls_addr,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_err,
  output logic        o_mem_ce,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [15:0] o_perf_conflicts
`endif
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;
  logic          w_conflict;
  logic          w_if_win;
  logic          w_ls_win;
  logic [31:0]   w_addr;
  logic          w_ok;
  logic [31:0]   w_rdata;

  assign w_conflict = i_if_req && i_ls_req;

  // LS has priority on a conflict until IF has lost STARVE_LIMIT times in a row.
  always_comb begin
    w_if_win = 1'b0;
    w_ls_win = 1'b0;
    if (!i_rst) begin
      w_if_win = i_if_req && (!i_ls_req || (r_starve_cnt == LIMIT));
      w_ls_win = i_ls_req && !w_if_win;
    end
  end

  assign w_addr  = w_if_win ? i_if_addr : i_ls_addr;
  assign w_ok    = (w_addr[1:0] == 2'b00) && ({2'b00, w_addr[31:2]} < DEPTH);
  assign w_rdata = w_ok ? i_mem_data : 32'h0;

  assign o_if_gnt   = w_if_win;
  assign o_ls_gnt   = w_ls_win;
  assign o_mem_ce   = (w_if_win || w_ls_win) && w_ok;
  assign o_mem_addr = o_mem_ce ? w_addr : 32'h0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (w_if_win) begin
      r_starve_cnt <= '0;
    end else if (w_conflict && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Losing port keeps its last rdata/err; only rvalid is pulsed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= 32'h0;
      o_if_err    <= 1'b0;
      o_ls_rvalid <= 1'b0;
      o_ls_rdata  <= 32'h0;
      o_ls_err    <= 1'b0;
    end else begin
      o_if_rvalid <= w_if_win;
      o_ls_rvalid <= w_ls_win;
      if (w_if_win) begin
        o_if_rdata <= w_rdata;
        o_if_err   <= !w_ok;
      end
      if (w_ls_win) begin
        o_ls_rdata <= w_rdata;
        o_ls_err   <= !w_ok;
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_conflicts <= 16'h0;
    end else if (w_conflict && (o_perf_conflicts != 16'hFFFF)) begin
      o_perf_conflicts <= o_perf_conflicts + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: stimulus pushes expected responses, a monitor pops them.
module tb_imem_port_arbiter;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_ce;
  logic [31:0] mem_addr, mem_data;
`ifdef IMEM_ARB_PERF_EN
  logic [15:0] perf;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cyc      = 0;
  exp_t        if_q[$];
  exp_t        ls_q[$];
  exp_t        e_if, e_ls;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [29:0] idx;
    idx = a[31:2];
    case (idx)
      30'd1:   return 32'h241D1000;
      30'd2:   return 32'h8F990008;
      default: return 32'hA5000000 | {2'b00, idx};
    endcase
  endfunction

  assign mem_data = mem_word(mem_addr);

  imem_port_arbiter #(.DEPTH(1024), .STARVE_LIMIT(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_gnt   (if_gnt),
    .o_if_rvalid(if_rvalid),
    .o_if_rdata (if_rdata),
    .o_if_err   (if_err),
    .i_ls_req   (ls_req),
    .i_ls_addr  (ls_addr),
    .o_ls_gnt   (ls_gnt),
    .o_ls_rvalid(ls_rvalid),
    .o_ls_rdata (ls_rdata),
    .o_ls_err   (ls_err),
    .o_mem_ce   (mem_ce),
    .o_mem_addr (mem_addr),
`ifdef IMEM_ARB_PERF_EN
    .o_perf_conflicts(perf),
`endif
    .i_mem_data (mem_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event/none expected none/event (cycle %0d)", nm, cyc);
  endtask

  // One cycle: drive, check combinational grant/port, queue the expected response.
  task automatic step(input logic ir, input logic [31:0] ia, input logic lr,
                      input logic [31:0] la, input logic eig, input logic elg,
                      input logic [31:0] ema, input logic [31:0] edat, input logic eerr,
                      input string nm);
    exp_t e;
    if_req  = ir;
    if_addr = ia;
    ls_req  = lr;
    ls_addr = la;
    #3;
    chk({nm, ".if_gnt"}, {31'b0, if_gnt}, {31'b0, eig});
    chk({nm, ".ls_gnt"}, {31'b0, ls_gnt}, {31'b0, elg});
    chk({nm, ".mem_ce"}, {31'b0, mem_ce}, {31'b0, (eig || elg) && !eerr});
    chk({nm, ".mem_addr"}, mem_addr, ema);
    e.due  = cyc + 1;
    e.data = edat;
    e.err  = eerr;
    if (eig) if_q.push_back(e);
    if (elg) ls_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, nm);
  endtask

  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        fail_now("if_rvalid_unexpected");
      end else begin
        e_if = if_q.pop_front();
        chk("if_resp_cycle", cyc, e_if.due);
        chk("if_rdata", if_rdata, e_if.data);
        chk("if_err", {31'b0, if_err}, {31'b0, e_if.err});
      end
    end else if (if_q.size() != 0 && if_q[0].due <= cyc) begin
      fail_now("if_rvalid_missing");
      e_if = if_q.pop_front();
    end
    if (ls_rvalid) begin
      if (ls_q.size() == 0) begin
        fail_now("ls_rvalid_unexpected");
      end else begin
        e_ls = ls_q.pop_front();
        chk("ls_resp_cycle", cyc, e_ls.due);
        chk("ls_rdata", ls_rdata, e_ls.data);
        chk("ls_err", {31'b0, ls_err}, {31'b0, e_ls.err});
      end
    end else if (ls_q.size() != 0 && ls_q[0].due <= cyc) begin
      fail_now("ls_rvalid_missing");
      e_ls = ls_q.pop_front();
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, ".if_gnt"}, {31'b0, if_gnt}, 32'h0);
    chk({nm, ".ls_gnt"}, {31'b0, ls_gnt}, 32'h0);
    chk({nm, ".mem_ce"}, {31'b0, mem_ce}, 32'h0);
    chk({nm, ".mem_addr"}, mem_addr, 32'h0);
    chk({nm, ".if_rvalid"}, {31'b0, if_rvalid}, 32'h0);
    chk({nm, ".ls_rvalid"}, {31'b0, ls_rvalid}, 32'h0);
    chk({nm, ".if_rdata"}, if_rdata, 32'h0);
    chk({nm, ".ls_rdata"}, ls_rdata, 32'h0);
    chk({nm, ".if_err"}, {31'b0, if_err}, 32'h0);
    chk({nm, ".ls_err"}, {31'b0, ls_err}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h4;
    ls_req = 1'b1; ls_addr = 32'h8;
    @(posedge clk);
    #1;
    chk_all_zero("reset");
`ifdef IMEM_ARB_PERF_EN
    chk("reset.perf", {16'b0, perf}, 32'h0);
`endif
    if_req = 1'b0;
    ls_req = 1'b0;
    rst    = 1'b0;

    // IF alone, then an idle cycle
    step(1, 32'h4, 0, 0, 1, 0, 32'h4, 32'h241D1000, 0, "if_only");
    idle("idle0");

    // LS access checks: misaligned, out of range, last valid word, normal
    step(0, 0, 1, 32'h6, 0, 1, 32'h0, 32'h0, 1, "ls_misaligned");
    step(0, 0, 1, 32'h1000, 0, 1, 32'h0, 32'h0, 1, "ls_out_of_range");
    step(0, 0, 1, 32'hFFC, 0, 1, 32'hFFC, 32'hA50003FF, 0, "ls_last_word");
    step(0, 0, 1, 32'h8, 0, 1, 32'h8, 32'h8F990008, 0, "ls_word2");

    // Continuous conflict: LS x4 then IF, twice
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        step(1, 32'h4, 1, 32'h8, 1, 0, 32'h4, 32'h241D1000, 0, "conflict_if");
      else
        step(1, 32'h4, 1, 32'h8, 0, 1, 32'h8, 32'h8F990008, 0, "conflict_ls");
    end

    // Starve count survives IF-idle cycles; IF then wins with a misaligned address
    step(1, 32'h2, 1, 32'h8, 0, 1, 32'h8, 32'h8F990008, 0, "hold_ls1");
    step(1, 32'h2, 1, 32'h8, 0, 1, 32'h8, 32'h8F990008, 0, "hold_ls2");
    step(0, 32'h0, 1, 32'h4, 0, 1, 32'h4, 32'h241D1000, 0, "hold_ls_only");
    step(1, 32'h2, 1, 32'h8, 0, 1, 32'h8, 32'h8F990008, 0, "hold_ls3");
    step(1, 32'h2, 1, 32'h8, 0, 1, 32'h8, 32'h8F990008, 0, "hold_ls4");
    step(1, 32'h2, 1, 32'h8, 1, 0, 32'h0, 32'h0, 1, "hold_if_err");

    // IF back-to-back over words 0..7, then a conflict still goes to LS
    for (int k = 0; k < 8; k++) begin
      step(1, 32'(k * 4), 0, 0, 1, 0, 32'(k * 4),
           (k == 1) ? 32'h241D1000 : (k == 2) ? 32'h8F990008 : (32'hA5000000 | 32'(k)),
           0, "if_burst");
    end
    step(1, 32'h4, 1, 32'h8, 0, 1, 32'h8, 32'h8F990008, 0, "post_burst_conflict");
    idle("idle1");

    // Reset lands in the same cycle as an IF grant
    if_req  = 1'b1;
    if_addr = 32'h4;
    #2;
    chk("rst_mid.if_gnt_before", {31'b0, if_gnt}, 32'h1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 32'h8, 0, 0, 1, 0, 32'h8, 32'h8F990008, 0, "after_rst");
    idle("idle2");

`ifdef IMEM_ARB_PERF_EN
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        step(1, 32'h4, 1, 32'h8, 1, 0, 32'h4, 32'h241D1000, 0, "perf_if");
      else
        step(1, 32'h4, 1, 32'h8, 0, 1, 32'h8, 32'h8F990008, 0, "perf_ls");
    end
    idle("idle3");
    chk("perf_count", {16'b0, perf}, 32'd10);
    idle("idle4");
    rst = 1'b1;
    #1;
    chk("perf_reset", {16'b0, perf}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    idle("drain0");
    idle("drain1");
    chk("if_queue_empty", 32'(if_q.size()), 32'h0);
    chk("ls_queue_empty", 32'(ls_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
